mem_arbiter: RTL
================

# mem_arbiter

Two-port round-robin arbiter that shares the single-ported data memory between instruction fetch (port 0) and load/store (port 1) in the single-cycle core's memory subsystem. It issues one memory command per grant, tracks the one outstanding read through a configurable read latency, and routes read data back to the requester that issued it. Memory-side signals have the same shape as the memory interface: `addr`, `wr_en`, `rd_en`, `wdata`, `rdata`.

## Interface

- `AW`, 32, address width.
- `DW`, 32, data width.
- `RD_LAT`, 1, memory read latency in cycles, legal range 1..4.

- `clk`  in  1  clock, all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `p0_req` / `p1_req`  in  1  request. Held high until the matching `gnt`.
- `p0_we` / `p1_we`  in  1  1 = write, 0 = read. Held stable while `req` is high.
- `p0_addr` / `p1_addr`  in  AW  request address. Held stable while `req` is high.
- `p0_wdata` / `p1_wdata`  in  DW  write data. Held stable while `req` is high.
- `p0_gnt` / `p1_gnt`  out  1  combinational grant. The request is accepted in this cycle.
- `p0_rvalid` / `p1_rvalid`  out  1  one-cycle read-data-valid strobe.
- `p0_rdata` / `p1_rdata`  out  DW  equals `mem_rdata` when the matching `rvalid` is high, otherwise 0.
- `mem_addr`  out  AW  memory address.
- `mem_wr_en`  out  1  memory write enable.
- `mem_rd_en`  out  1  memory read enable.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid `RD_LAT` cycles after a read is issued.
- `busy`  out  1  high while grants are blocked by an in-flight read.

## Operation

**State**
- `last` (1 bit): port granted most recently. Reset value 1.
- `cnt` (3 bits): read countdown. Reset value 0.
- `owner` (1 bit): port that owns the in-flight read. Reset value 0.

**Grant eligibility**
- Granting is allowed when `cnt <= 1`.

**Arbitration** (only when granting is allowed)
- Exactly one request pending: that port is granted.
- Both requests pending: the port other than `last` is granted.
- On each grant, `last` is updated to the granted port.
- At most one `gnt` is high per cycle.

**Command mux**
- In a grant cycle, `mem_addr`, `mem_wdata` and `mem_wr_en = we` come from the winning port, with `mem_rd_en = ~we`.
- With no grant, all `mem_*` outputs are 0.

**Writes**
- A write completes in its grant cycle.
- `cnt` is unaffected by a write, so back-to-back write grants are legal.

**Reads**
- A read grant loads `cnt <= RD_LAT` and `owner <= winner`.
- When no read is granted, `cnt` decrements at each posedge while nonzero.
- `rvalid[owner]` is high exactly in the cycle where `cnt == 1`.

**Overlapped grant**
- A new grant (read or write) is allowed in the same cycle as a returning `rvalid`.
- If that new grant is a read, `cnt` and `owner` are reloaded at that posedge.

**Busy**
- `busy = (cnt > 1)`.

**Reset**
- Reset is asynchronous and clears `last`, `cnt` and `owner` to their reset values.
- During reset all outputs are 0: every `gnt`, `rvalid`, `rdata`, all `mem_*` outputs and `busy`.
- An in-flight read at reset is dropped and its `rvalid` never fires. `mem_rdata` is ignored after reset.

## Timing

- Grant to memory command: 0 cycles. The memory samples the command at the posedge that ends the grant cycle.
- Read issue to `rvalid`: a read granted in cycle T returns `rvalid` in cycle T+`RD_LAT`.
- Bubble cycles between consecutive read grants: `RD_LAT`-1. With `RD_LAT`=1 there is no bubble.
- A pending request while `busy` is high gets no `gnt` and keeps waiting. Arbitration resumes in the cycle where `cnt` reaches 1.
- Outputs that are registered: none. `gnt`, `rvalid` and the `mem_*` outputs are decoded from state and inputs.

## Test plan

1. **Reset defaults.** Assert `reset` with both requests high → all outputs 0. After release, port 0 is granted first because `last` = 1.
2. **Back-to-back writes, `RD_LAT`=1.** Port 1 writes 0xDEADBEEF to 0x10 in one cycle, then 0x12345678 to 0x14 in the next → `p1_gnt` is high 2 consecutive cycles, `mem_wr_en` = 1, `mem_addr` shows 0x10 then 0x14. Reading 0x14 back gives `p1_rvalid` one cycle later with `p1_rdata` = 0x12345678.
3. **Round-robin fairness, `RD_LAT`=1.** Both ports issue reads continuously for 8 grants → grants alternate 0,1,0,1,… Each `rvalid` lands on the owning port one cycle after its grant.
4. **Latency stall, `RD_LAT`=3.** Port 0 reads at cycle T while port 1 requests at T+1 → `busy` is high at T+1 and T+2, and `p1_gnt` stays low. `p0_rvalid` and `p1_gnt` are both high at T+3.
5. **Reset mid-read, `RD_LAT`=3.** Port 1 reads at T and `reset` is pulsed at T+1 → no `p1_rvalid` ever appears, `busy` = 0 immediately, and the next grant goes to port 0.
6. **Single requester dominance.** Only port 1 requests, 4 reads with `RD_LAT`=2 → port 1 is granted every 2 cycles with no starvation stall, and `p0_rvalid` / `p0_rdata` stay 0 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter sharing one single-ported data
// memory between instruction fetch (port 0) and load/store (port 1).
// Issues one memory command per grant. Tracks the single outstanding read
// through RD_LAT cycles, then returns its data to the port that issued it.
//
// Ports
//   clk, reset                     clock, async active-high reset
//   pN_req/we/addr/wdata  (in)     request from port N, held until pN_gnt
//   pN_gnt                (out)    combinational grant
//   pN_rvalid/rdata       (out)    read return strobe and data (0 when idle)
//   mem_addr/wr_en/rd_en/wdata     command to memory, 0 when nothing granted
//   mem_rdata             (in)     memory read data, RD_LAT cycles after issue
//   busy                  (out)    grants blocked by an in-flight read
module mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1    // 1..4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_gnt,
  output logic          p1_gnt,
  output logic          p0_rvalid,
  output logic          p1_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  logic       last_q, last_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;

  logic          can_gnt, any_gnt, win, win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          ret;
  logic [1:0]    rv;
  logic [1:0][DW-1:0] rd;

  // cnt == 1 is the return cycle of the in-flight read; arbitration is
  // already open there so a new command overlaps the returning data.
  assign can_gnt = ~reset & (cnt_q <= 3'd1);
  assign busy    = ~reset & (cnt_q > 3'd1);

  // Contention goes to the port that was not granted last.
  assign p0_gnt  = can_gnt & p0_req & (~p1_req | last_q);
  assign p1_gnt  = can_gnt & p1_req & (~p0_req | ~last_q);
  assign any_gnt = p0_gnt | p1_gnt;
  assign win     = p1_gnt;

  assign win_we    = win ? p1_we    : p0_we;
  assign win_addr  = win ? p1_addr  : p0_addr;
  assign win_wdata = win ? p1_wdata : p0_wdata;

  assign mem_addr  = any_gnt ? win_addr  : '0;
  assign mem_wdata = any_gnt ? win_wdata : '0;
  assign mem_wr_en = any_gnt &  win_we;
  assign mem_rd_en = any_gnt & ~win_we;

  // Read return steering, one slice per port.
  assign ret = ~reset & (cnt_q == 3'd1);
  for (genvar i = 0; i < 2; i++) begin : g_ret
    assign rv[i] = ret & (owner_q == 1'(i));
    assign rd[i] = rv[i] ? mem_rdata : '0;
  end
  assign p0_rvalid = rv[0];
  assign p1_rvalid = rv[1];
  assign p0_rdata  = rd[0];
  assign p1_rdata  = rd[1];

  always_comb begin
    last_d  = last_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
    if (any_gnt) begin
      last_d = win;
      // Writes finish in the grant cycle and leave the countdown alone.
      if (!win_we) begin
        cnt_d   = LAT;
        owner_d = win;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q  <= 1'b1;
      cnt_q   <= 3'd0;
      owner_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

endmodule
